// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush, memory-busy freeze.
// Latency: combinational outputs, registered counters; MemBusy freezes all state.
module hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IDRs1,
    input  logic [4:0]       IDRs2,
    input  logic             IDUseRs1,
    input  logic             IDUseRs2,
    input  logic [4:0]       EXRd,
    input  logic             EXMemRead,
    input  logic             EXBranchTaken,
    input  logic             MemBusy,
    output logic             DataHazard,
    output logic             ControlHazard,
    output logic             IDEXFlush,
    output logic             PcHold,
    output logic             PipeFreeze,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

    localparam logic [3:0] LU_INIT = 4'(LOAD_USE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       flush_pending;
    logic       lu_now;

    assign lu_now = EXMemRead && (EXRd != 5'd0) &&
                    ((IDUseRs1 && (IDRs1 == EXRd)) || (IDUseRs2 && (IDRs2 == EXRd)));

    assign PipeFreeze    = MemBusy;
    assign ControlHazard = !MemBusy && (EXBranchTaken || flush_pending);
    assign DataHazard    = !MemBusy && !ControlHazard && (lu_now || (state == LU_STALL));
    assign IDEXFlush     = ControlHazard || DataHazard;
    assign PcHold        = PipeFreeze || DataHazard;

    // While frozen nothing advances; a branch seen then is parked for the first free cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            cnt           <= '0;
            flush_pending <= 1'b0;
        end else if (MemBusy) begin
            if (EXBranchTaken)
                flush_pending <= 1'b1;
        end else begin
            if (ControlHazard)
                flush_pending <= 1'b0;
            if (state == RUN) begin
                if (DataHazard && lu_now && (LOAD_USE_CYCLES > 1)) begin
                    state <= LU_STALL;
                    cnt   <= LU_INIT;
                end
            end else begin
                // A flush discards the stalled instruction, so the remaining bubbles are dropped.
                if (ControlHazard || (cnt == 4'd1)) begin
                    state <= RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (DataHazard && (StallCycles != {CNT_W{1'b1}}))
                StallCycles <= StallCycles + CNT_W'(1);
            if (ControlHazard && (FlushCount != {CNT_W{1'b1}}))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle/16-bit and 2-cycle/4-bit counters)
// checked against a bubble-count reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] IDRs1, IDRs2, EXRd;
    logic       IDUseRs1, IDUseRs2, EXMemRead, EXBranchTaken, MemBusy;

    logic        a_dh, a_ch, a_idex, a_pc, a_pf;
    logic [15:0] a_sc, a_fc;
    logic        b_dh, b_ch, b_idex, b_pc, b_pf;
    logic [3:0]  b_sc, b_fc;

    hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .IDRs1(IDRs1), .IDRs2(IDRs2),
        .IDUseRs1(IDUseRs1), .IDUseRs2(IDUseRs2), .EXRd(EXRd),
        .EXMemRead(EXMemRead), .EXBranchTaken(EXBranchTaken), .MemBusy(MemBusy),
        .DataHazard(a_dh), .ControlHazard(a_ch), .IDEXFlush(a_idex), .PcHold(a_pc),
        .PipeFreeze(a_pf), .StallCycles(a_sc), .FlushCount(a_fc));

    hazard_ctrl #(.LOAD_USE_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .IDRs1(IDRs1), .IDRs2(IDRs2),
        .IDUseRs1(IDUseRs1), .IDUseRs2(IDUseRs2), .EXRd(EXRd),
        .EXMemRead(EXMemRead), .EXBranchTaken(EXBranchTaken), .MemBusy(MemBusy),
        .DataHazard(b_dh), .ControlHazard(b_ch), .IDEXFlush(b_idex), .PcHold(b_pc),
        .PipeFreeze(b_pf), .StallCycles(b_sc), .FlushCount(b_fc));

    logic [4:0]  obs_a, obs_b;
    logic [39:0] obs_cnt;
    assign obs_a   = {a_dh, a_ch, a_idex, a_pc, a_pf};
    assign obs_b   = {b_dh, b_ch, b_idex, b_pc, b_pf};
    assign obs_cnt = {a_sc, a_fc, b_sc, b_fc};

    int tests = 0;
    int fails = 0;

    // Reference model: remaining bubbles, parked flush, counters, per instance.
    int rem  [2];
    int pend [2];
    int scm  [2];
    int fcm  [2];

    function automatic int luc(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int maxc(int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic logic lu_hit();
        return EXMemRead && (EXRd != 0) &&
               ((IDUseRs1 && IDRs1 == EXRd) || (IDUseRs2 && IDRs2 == EXRd));
    endfunction

    // {data, control, idex, pchold, freeze}
    function automatic logic [4:0] exp_flags(int i);
        logic c, d;
        c = !MemBusy && (EXBranchTaken || pend[i] != 0);
        d = !MemBusy && !c && (lu_hit() || rem[i] > 0);
        return {d, c, c | d, MemBusy | d, MemBusy};
    endfunction

    function automatic logic [39:0] exp_cnts();
        return {16'(scm[0]), 16'(fcm[0]), 4'(scm[1]), 4'(fcm[1])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; pend[i] = 0; scm[i] = 0; fcm[i] = 0;
        end
    endtask

    task automatic clear_in();
        IDRs1 = 0; IDRs2 = 0; EXRd = 0; IDUseRs1 = 0; IDUseRs2 = 0;
        EXMemRead = 0; EXBranchTaken = 0; MemBusy = 0;
    endtask

    task automatic set_lu();
        EXMemRead = 1; EXRd = 5'd5; IDRs1 = 5'd5; IDUseRs1 = 1;
    endtask

    task automatic advance();
        logic [4:0] f;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                f = exp_flags(i);
                if (MemBusy) begin
                    if (EXBranchTaken) pend[i] = 1;
                end else begin
                    pend[i] = 0;
                    if (f[3]) rem[i] = 0;
                    else if (f[4]) rem[i] = (rem[i] > 0) ? rem[i] - 1 : luc(i) - 1;
                end
                if (f[4] && scm[i] < maxc(i)) scm[i]++;
                if (f[3] && fcm[i] < maxc(i)) fcm[i]++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; clear_in(); model_reset();
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b_%b want 00000_00000", obs_a, obs_b);
        end
        tests++;
        if (obs_cnt !== 40'b0) begin
            fails++; $display("FAIL reset_cnts got %h want 0", obs_cnt);
        end
        advance();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_in(); set_lu();
        #1;
        tests++;
        if (obs_a !== 5'b10110) begin
            fails++; $display("FAIL lu1_flags got %b want 10110", obs_a);
        end
        tests++;
        if (obs_b !== exp_flags(1)) begin
            fails++; $display("FAIL lu2_flags got %b want %b", obs_b, exp_flags(1));
        end
        advance();
        @(negedge clk);
        clear_in();
        #1;
        tests++;
        if (a_sc !== 16'd1 || a_dh !== 1'b0) begin
            fails++; $display("FAIL lu1_after sc=%0d dh=%b want sc=1 dh=0", a_sc, a_dh);
        end
        tests++;
        if (b_dh !== 1'b1) begin
            fails++; $display("FAIL lu2_second_bubble dh=%b want 1", b_dh);
        end
        advance();
        @(negedge clk);
        #1;
        tests++;
        if (obs_b !== 5'b0 || obs_cnt !== exp_cnts()) begin
            fails++; $display("FAIL lu2_done flags=%b cnts=%h want 00000 %h", obs_b, obs_cnt, exp_cnts());
        end
        advance();
    endtask

    task automatic test_no_hazard();
        @(negedge clk);
        clear_in(); set_lu(); EXRd = 0; IDRs1 = 0;
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            fails++; $display("FAIL nh_x0 got %b_%b want 0", obs_a, obs_b);
        end
        advance();
        @(negedge clk);
        clear_in(); set_lu(); IDUseRs1 = 0;
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            fails++; $display("FAIL nh_nouse got %b_%b want 0", obs_a, obs_b);
        end
        advance();
        @(negedge clk);
        clear_in(); EXMemRead = 1; EXRd = 5'd9; IDRs2 = 5'd9; IDUseRs2 = 1;
        #1;
        tests++;
        if (obs_a !== 5'b10110) begin
            fails++; $display("FAIL rs2_hazard got %b want 10110", obs_a);
        end
        advance();
        @(negedge clk);
        clear_in();
        #1;
        tests++;
        if (obs_cnt !== exp_cnts()) begin
            fails++; $display("FAIL nh_cnts got %h want %h", obs_cnt, exp_cnts());
        end
        advance();
        advance();
    endtask

    task automatic test_freeze_in_stall();
        logic busy_pat [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int ndh, npf;
        ndh = 0; npf = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            clear_in();
            if (k < 5) set_lu();
            MemBusy = busy_pat[k];
            #1;
            if (k < 5) begin
                ndh += b_dh; npf += b_pf;
            end
            tests++;
            if (obs_b !== exp_flags(1)) begin
                fails++; $display("FAIL frz_step%0d got %b want %b", k, obs_b, exp_flags(1));
            end
            advance();
        end
        tests++;
        if (ndh != 2 || npf != 3) begin
            fails++; $display("FAIL frz_counts dh=%0d pf=%0d want dh=2 pf=3", ndh, npf);
        end
    endtask

    task automatic test_branch_vs_load();
        @(negedge clk);
        clear_in(); set_lu(); EXBranchTaken = 1;
        #1;
        tests++;
        if (obs_a !== 5'b01100 || obs_b !== 5'b01100) begin
            fails++; $display("FAIL br_lu got %b_%b want 01100_01100", obs_a, obs_b);
        end
        advance();
        @(negedge clk);
        clear_in();
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0) begin
            fails++; $display("FAIL br_lu_next got %b_%b want 0", obs_a, obs_b);
        end
        advance();
    endtask

    task automatic test_pending_flush();
        int start, nch, first;
        start = fcm[0]; nch = 0; first = -1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            clear_in();
            EXBranchTaken = (k == 0);
            MemBusy = (k < 2);
            #1;
            if (a_ch) begin
                nch++;
                if (first < 0) first = k;
            end
            tests++;
            if (obs_a !== exp_flags(0) || obs_b !== exp_flags(1)) begin
                fails++; $display("FAIL pend_step%0d got %b_%b want %b_%b", k, obs_a, obs_b, exp_flags(0), exp_flags(1));
            end
            advance();
        end
        tests++;
        if (nch != 1 || first != 2 || a_fc !== 16'(start + 1)) begin
            fails++; $display("FAIL pend_flush n=%0d at=%0d fc=%0d want n=1 at=2 fc=%0d", nch, first, a_fc, start + 1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            IDRs1 = 5'($urandom_range(0, 3));
            IDRs2 = 5'($urandom_range(0, 3));
            EXRd  = 5'($urandom_range(0, 3));
            IDUseRs1 = 1'($urandom_range(0, 1));
            IDUseRs2 = 1'($urandom_range(0, 1));
            EXMemRead = 1'($urandom_range(0, 1));
            EXBranchTaken = ($urandom_range(0, 7) == 0);
            MemBusy = ($urandom_range(0, 4) == 0);
            if (!rst_n) model_reset();
            #1;
            tests++;
            if (obs_a !== exp_flags(0) || obs_b !== exp_flags(1) || obs_cnt !== exp_cnts()) begin
                fails++;
                $display("FAIL rand%0d got %b_%b %h want %b_%b %h", k, obs_a, obs_b, obs_cnt,
                         exp_flags(0), exp_flags(1), exp_cnts());
            end
            advance();
        end
        @(negedge clk);
        rst_n = 1; clear_in();
        advance();
    endtask

    task automatic test_saturation_and_reset();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            clear_in(); set_lu();
            advance();
        end
        @(negedge clk);
        clear_in();
        #1;
        tests++;
        if (b_sc !== 4'hF || obs_cnt !== exp_cnts()) begin
            fails++; $display("FAIL sat b_sc=%0d cnts=%h want 15 %h", b_sc, obs_cnt, exp_cnts());
        end
        advance();
        advance();
        // Put instance b mid-stall with a parked flush, then reset.
        @(negedge clk);
        clear_in(); set_lu();
        advance();
        @(negedge clk);
        clear_in(); MemBusy = 1; EXBranchTaken = 1;
        advance();
        @(negedge clk);
        clear_in();
        #1;
        tests++;
        if (b_ch !== 1'b1) begin
            fails++; $display("FAIL pre_reset_pending ch=%b want 1", b_ch);
        end
        rst_n = 0; model_reset();
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0 || obs_cnt !== 40'b0) begin
            fails++; $display("FAIL reset_mid got %b_%b %h want 0", obs_a, obs_b, obs_cnt);
        end
        advance();
        @(negedge clk);
        rst_n = 1;
        #1;
        tests++;
        if (obs_a !== 5'b0 || obs_b !== 5'b0 || obs_cnt !== 40'b0) begin
            fails++; $display("FAIL after_reset got %b_%b %h want 0", obs_a, obs_b, obs_cnt);
        end
        advance();
    endtask

    initial begin
        rst_n = 0;
        clear_in();
        model_reset();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_freeze_in_stall();
        test_branch_vs_load();
        test_pending_flush();
        test_random();
        test_saturation_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
